tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of trigger channels.
REQ-002 SHALL have parameter DELAY_W, default 16: width of each per-channel delay.
REQ-003 SHALL have parameter PERIOD_W, default 27: width of period and position counter.
REQ-004 SHALL have port clk_in  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_in  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port tick_in  input  1: event enable; counter advances only on cycles where it is 1.
REQ-007 SHALL have port start_in  input  1: single-cycle request to begin a burst.
REQ-008 SHALL have port abort_in  input  1: terminate the active burst.
REQ-009 SHALL have port period_in  input  PERIOD_W: ticks per period; sampled on accepted start.
REQ-010 SHALL have port burst_len_in  input  8: number of periods per burst; sampled on accepted start.
REQ-011 SHALL have port delays_in  input  NUM_CH*DELAY_W: per-channel tick offset; channel k in bits [k*DELAY_W +: DELAY_W]; sampled on accepted start.
REQ-012 SHALL have port fire_out  output  NUM_CH: per-channel one-cycle trigger pulses.
REQ-013 SHALL have port busy_out  output  1: high while state is RUN.
REQ-014 SHALL have port done_out  output  1: one-cycle pulse on normal burst completion.
REQ-015 SHALL have port err_out  output  1: one-cycle pulse on rejected start.
REQ-016 SHALL have port pos_out  output  PERIOD_W: current tick position within period.
REQ-017 SHALL have port period_idx_out  output  8: index of current period, 0-based.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-019 In IDLE, start_in=1 with period_in!=0 and burst_len_in!=0 SHALL latch configuration, clear pos and period_idx to 0, and enter RUN next cycle.
REQ-020 In IDLE, start_in=1 with period_in==0 or burst_len_in==0 SHALL stay IDLE and pulse err_out for one cycle on the next cycle.
REQ-021 start_in in RUN or DONE SHALL be ignored; no err_out and no reconfiguration.
REQ-022 In RUN, on a cycle with tick_in=1, fire_out[k] SHALL be 1 on the next cycle iff pos==latched delay[k]; otherwise fire_out[k]=0.
REQ-023 In RUN with tick_in=1, pos SHALL increment, or wrap to 0 when pos==period-1, in which case period_idx SHALL increment.
REQ-024 In RUN with tick_in=0, pos, period_idx and fire_out SHALL hold and be 0 respectively; no channel fires.
REQ-025 Delay >= period SHALL cause that channel never to fire; multiple channels with equal delays SHALL fire in the same cycle.
REQ-026 A tick with pos==period-1 and period_idx==burst_len-1 SHALL enter DONE next cycle, with done_out=1 in that cycle; fire_out for that final tick SHALL still be produced.
REQ-027 DONE SHALL last exactly one cycle, then go to IDLE; busy_out=0 in DONE.
REQ-028 abort_in=1 in RUN SHALL enter IDLE next cycle with fire_out=0, no done_out; abort_in has priority over tick_in in the same cycle.
REQ-029 abort_in in IDLE or DONE SHALL have no effect.
REQ-030 In IDLE, pos_out and period_idx_out SHALL hold their last values until the next accepted start.

Reset
REQ-031 When rst_in=0 at a clock edge, state SHALL become IDLE, and fire_out, busy_out, done_out, err_out, pos_out and period_idx_out SHALL become 0, overriding all other inputs, including mid-burst.
REQ-032 The first accepted start after reset release SHALL behave identically to any later start.

Verification
REQ-033 Start with period=4, burst=2, delays={0,1,3,5}, tick every cycle -> fire_out[0] at ticks 0 and 4, [1] at ticks 1 and 5, [2] at ticks 3 and 7, [3] never; done_out once after tick 7; busy_out high for 8 cycles.
REQ-034 Same config with tick_in high every 3rd cycle -> identical fire sequence in tick order; pos_out holds between ticks; no fire on non-tick cycles.
REQ-035 Start with period=0, then separately with burst=0 -> err_out one pulse each, busy_out stays 0, fire_out stays 0.
REQ-036 Abort asserted together with the tick at pos=2 of period 0 -> no fire for that tick, IDLE next cycle, done_out never asserted; a new start is then accepted.
REQ-037 rst_in=0 for one cycle mid-burst, with start_in asserted during RUN -> all outputs 0 after the reset edge, state IDLE, and the earlier start during RUN causes no reconfiguration.
REQ-038 Period=1, burst=3, all delays 0, tick every cycle -> all channels fire on 3 consecutive cycles; done_out is coincident with the third fire.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: burst trigger generator. After an accepted start it counts
// tick_in events through burst_len periods of period ticks each. It pulses
// fire_out[k] whenever the in-period position equals channel k's delay.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; pos/period_idx keep their last values
//   RUN   | counting ticks, firing channels, busy_out high
//   DONE  | single-cycle completion state, done_out high, then IDLE
module tick_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int DELAY_W  = 16,
  parameter int PERIOD_W = 27
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        tick_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic [PERIOD_W-1:0]         period_in,
  input  logic [7:0]                  burst_len_in,
  input  logic [NUM_CH*DELAY_W-1:0]   delays_in,
  output logic [NUM_CH-1:0]           fire_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        err_out,
  output logic [PERIOD_W-1:0]         pos_out,
  output logic [7:0]                  period_idx_out
);

  // Compare width wide enough for both pos and delay so a delay >= period
  // can never alias onto a reachable position.
  localparam int CMP_W = (PERIOD_W > DELAY_W) ? PERIOD_W : DELAY_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  logic [PERIOD_W-1:0]         r_period;
  logic [7:0]                  r_burst;
  logic [NUM_CH*DELAY_W-1:0]   r_delays;
  logic [PERIOD_W-1:0]         r_pos;
  logic [7:0]                  r_idx;
  logic [NUM_CH-1:0]           r_fire;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;

  logic [NUM_CH-1:0]           w_hit;
  logic                        w_cfg_ok;
  logic                        w_last_pos;
  logic                        w_last_per;

  assign w_cfg_ok   = (period_in != '0) && (burst_len_in != 8'd0);
  assign w_last_pos = (r_pos == (r_period - PERIOD_W'(1)));
  assign w_last_per = (r_idx == (r_burst - 8'd1));

  // Per-channel match of the current position against the latched delay.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_hit[k] = (CMP_W'(r_pos) == CMP_W'(r_delays[k*DELAY_W +: DELAY_W]));
    end
  end

  // Sequencer: state, configuration latch, position counters and all outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state  <= ST_IDLE;
      r_period <= '0;
      r_burst  <= '0;
      r_delays <= '0;
      r_pos    <= '0;
      r_idx    <= '0;
      r_fire   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fire <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            if (w_cfg_ok) begin
              r_period <= period_in;
              r_burst  <= burst_len_in;
              r_delays <= delays_in;
              r_pos    <= '0;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              r_state  <= ST_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a coincident tick: that tick produces no fire.
          if (abort_in) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (tick_in) begin
            r_fire <= w_hit;
            if (w_last_pos) begin
              r_pos <= '0;
              r_idx <= r_idx + 8'd1;
              if (w_last_per) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end else begin
              r_pos <= r_pos + PERIOD_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fire_out       = r_fire;
  assign busy_out       = r_busy;
  assign done_out       = r_done;
  assign err_out        = r_err;
  assign pos_out        = r_pos;
  assign period_idx_out = r_idx;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed bursts, with expected output events
// queued by the stimulus and consumed by an independent output monitor.
module tb_tick_scheduler;

  localparam int NUM_CH   = 4;
  localparam int DELAY_W  = 16;
  localparam int PERIOD_W = 27;

  logic                       clk_in = 1'b0;
  logic                       rst_in;
  logic                       tick_in;
  logic                       start_in;
  logic                       abort_in;
  logic [PERIOD_W-1:0]        period_in;
  logic [7:0]                 burst_len_in;
  logic [NUM_CH*DELAY_W-1:0]  delays_in;
  logic [NUM_CH-1:0]          fire_out;
  logic                       busy_out;
  logic                       done_out;
  logic                       err_out;
  logic [PERIOD_W-1:0]        pos_out;
  logic [7:0]                 period_idx_out;

  typedef struct packed {
    logic [3:0] fire;
    logic       done;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt;

  tick_scheduler #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .PERIOD_W(PERIOD_W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tick_in        (tick_in),
    .start_in       (start_in),
    .abort_in       (abort_in),
    .period_in      (period_in),
    .burst_len_in   (burst_len_in),
    .delays_in      (delays_in),
    .fire_out       (fire_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .err_out        (err_out),
    .pos_out        (pos_out),
    .period_idx_out (period_idx_out)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: every output event is matched against the head of the queue.
  always @(negedge clk_in) begin
    if ((fire_out != 4'd0) || done_out || err_out) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got fire=%b done=%b err=%b, expected no event",
                 fire_out, done_out, err_out);
      end else begin
        mon_e = q.pop_front();
        if ({fire_out, done_out, err_out} !== mon_e) begin
          n_err++;
          $display("FAIL event_match: got fire=%b done=%b err=%b, expected fire=%b done=%b err=%b",
                   fire_out, done_out, err_out, mon_e.fire, mon_e.done, mon_e.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] f, input logic d, input logic e);
    exp_t t;
    t.fire = f;
    t.done = d;
    t.err  = e;
    q.push_back(t);
  endtask

  function automatic logic [63:0] dly4(input logic [15:0] d0, input logic [15:0] d1,
                                       input logic [15:0] d2, input logic [15:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_burst(input logic [PERIOD_W-1:0] per, input logic [7:0] bl,
                             input logic [63:0] dl, input logic tk);
    period_in    = per;
    burst_len_in = bl;
    delays_in    = dl;
    tick_in      = tk;
    start_in     = 1'b1;
    cyc();
    start_in     = 1'b0;
  endtask

  initial begin
    rst_in       = 1'b0;
    tick_in      = 1'b0;
    start_in     = 1'b0;
    abort_in     = 1'b0;
    period_in    = '0;
    burst_len_in = '0;
    delays_in    = '0;

    // Reset state
    repeat (2) cyc();
    @(negedge clk_in);
    chk("rst_fire", 32'(fire_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_done", 32'(done_out), 0);
    chk("rst_err",  32'(err_out), 0);
    chk("rst_pos",  32'(pos_out), 0);
    chk("rst_idx",  32'(period_idx_out), 0);
    rst_in = 1'b1;
    cyc();

    // Period 4, burst 2, delays {0,1,3,5}, tick every cycle
    push(4'b0001, 1'b0, 1'b0);
    push(4'b0010, 1'b0, 1'b0);
    push(4'b0100, 1'b0, 1'b0);
    push(4'b0001, 1'b0, 1'b0);
    push(4'b0010, 1'b0, 1'b0);
    push(4'b0100, 1'b1, 1'b0);
    start_burst(27'd4, 8'd2, dly4(16'd0, 16'd1, 16'd3, 16'd5), 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      if (busy_out) busy_cnt++;
    end
    tick_in = 1'b0;
    chk("t1_busy_cycles", 32'(busy_cnt), 8);
    chk("t1_idle_busy", 32'(busy_out), 0);
    chk("t1_queue_empty", 32'(q.size()), 0);

    // Same config, tick every third cycle; position holds between ticks
    push(4'b0001, 1'b0, 1'b0);
    push(4'b0010, 1'b0, 1'b0);
    push(4'b0100, 1'b0, 1'b0);
    push(4'b0001, 1'b0, 1'b0);
    push(4'b0010, 1'b0, 1'b0);
    push(4'b0100, 1'b1, 1'b0);
    start_burst(27'd4, 8'd2, dly4(16'd0, 16'd1, 16'd3, 16'd5), 1'b0);
    for (int n = 0; n < 8; n++) begin
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      if (n < 7) begin
        @(negedge clk_in);
        chk("t2_pos_after_tick", 32'(pos_out), 32'((n + 1) % 4));
        chk("t2_idx_after_tick", 32'(period_idx_out), (n < 3) ? 32'd0 : 32'd1);
        @(negedge clk_in);
        chk("t2_pos_hold", 32'(pos_out), 32'((n + 1) % 4));
        chk("t2_no_fire_idle_cycle", 32'(fire_out), 0);
        cyc();
      end else begin
        repeat (2) cyc();
      end
    end
    repeat (2) cyc();
    chk("t2_idle_busy", 32'(busy_out), 0);
    chk("t2_queue_empty", 32'(q.size()), 0);

    // Rejected starts: period 0, then burst 0
    push(4'b0000, 1'b0, 1'b1);
    start_burst(27'd0, 8'd2, dly4(16'd0, 16'd1, 16'd3, 16'd5), 1'b1);
    @(negedge clk_in);
    chk("t3a_busy", 32'(busy_out), 0);
    repeat (3) cyc();
    chk("t3a_busy_later", 32'(busy_out), 0);
    push(4'b0000, 1'b0, 1'b1);
    start_burst(27'd4, 8'd0, dly4(16'd0, 16'd1, 16'd3, 16'd5), 1'b1);
    @(negedge clk_in);
    chk("t3b_busy", 32'(busy_out), 0);
    repeat (3) cyc();
    tick_in = 1'b0;
    chk("t3b_busy_later", 32'(busy_out), 0);
    chk("t3_queue_empty", 32'(q.size()), 0);

    // Abort together with the tick at pos 2, then a fresh start
    push(4'b0001, 1'b0, 1'b0);
    push(4'b0010, 1'b0, 1'b0);
    start_burst(27'd4, 8'd2, dly4(16'd0, 16'd1, 16'd2, 16'd9), 1'b1);
    cyc();
    cyc();
    abort_in = 1'b1;
    cyc();
    abort_in = 1'b0;
    tick_in  = 1'b0;
    @(negedge clk_in);
    chk("t4_abort_busy", 32'(busy_out), 0);
    chk("t4_abort_fire", 32'(fire_out), 0);
    chk("t4_abort_done", 32'(done_out), 0);
    repeat (3) cyc();
    chk("t4_abort_queue_empty", 32'(q.size()), 0);
    push(4'b1111, 1'b1, 1'b0);
    start_burst(27'd2, 8'd1, dly4(16'd1, 16'd1, 16'd1, 16'd1), 1'b1);
    @(negedge clk_in);
    chk("t4_restart_busy", 32'(busy_out), 1);
    repeat (4) cyc();
    tick_in = 1'b0;
    chk("t4_restart_idle", 32'(busy_out), 0);
    chk("t4_restart_queue_empty", 32'(q.size()), 0);

    // Start during RUN is ignored; reset mid-burst clears everything
    push(4'b0001, 1'b0, 1'b0);
    push(4'b0010, 1'b0, 1'b0);
    start_burst(27'd4, 8'd2, dly4(16'd0, 16'd1, 16'd3, 16'd5), 1'b1);
    cyc();
    period_in    = 27'd2;
    burst_len_in = 8'd1;
    delays_in    = '0;
    start_in     = 1'b1;
    cyc();
    start_in = 1'b0;
    @(negedge clk_in);
    chk("t5_run_start_pos", 32'(pos_out), 2);
    chk("t5_run_start_busy", 32'(busy_out), 1);
    chk("t5_run_start_err", 32'(err_out), 0);
    rst_in = 1'b0;
    cyc();
    rst_in  = 1'b1;
    tick_in = 1'b0;
    @(negedge clk_in);
    chk("t5_rst_fire", 32'(fire_out), 0);
    chk("t5_rst_busy", 32'(busy_out), 0);
    chk("t5_rst_done", 32'(done_out), 0);
    chk("t5_rst_err",  32'(err_out), 0);
    chk("t5_rst_pos",  32'(pos_out), 0);
    chk("t5_rst_idx",  32'(period_idx_out), 0);
    chk("t5_queue_empty", 32'(q.size()), 0);

    // Period 1, burst 3, all delays 0: three consecutive all-channel fires
    push(4'b1111, 1'b0, 1'b0);
    push(4'b1111, 1'b0, 1'b0);
    push(4'b1111, 1'b1, 1'b0);
    start_burst(27'd1, 8'd3, dly4(16'd0, 16'd0, 16'd0, 16'd0), 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (busy_out) busy_cnt++;
      if (i >= 1 && i <= 3) chk("t6_fire_consecutive", 32'(fire_out), 32'hF);
      if (i == 3) chk("t6_done_with_third_fire", 32'(done_out), 1);
    end
    tick_in = 1'b0;
    chk("t6_busy_cycles", 32'(busy_cnt), 3);

    repeat (3) cyc();
    chk("final_queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
